wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between NREQ writeback requesters (ALU result, load data, link/PC, flags-derived, etc.) using round-robin arbitration.
- Grants at most one requester per cycle and acknowledges it.
- Drives a registered write bundle: enable, 5-bit address, data, and a decoded one-hot 32-entry word-line select for the register-file write decoder tree.
- Register 31 is the zero register: writes to it are acknowledged but suppressed.

Parameters:
NREQ, 4, number of requesters (2..8).
ADDR_W, 5, register address width; select width is 2**ADDR_W.
DATA_W, 64, write data width.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
req  input  NREQ  per-requester write request; held until acknowledged.
req_addr  input  NREQ*ADDR_W  destination register per requester (requester i at [i*ADDR_W +: ADDR_W]).
req_data  input  NREQ*DATA_W  write data per requester (same packing).
busy  input  1  register file cannot accept a write this cycle.
ack  output  NREQ  one-hot grant, combinational, same cycle as decision.
wr_en  output  1  registered write enable to register file.
wr_addr  output  ADDR_W  registered write address.
wr_data  output  DATA_W  registered write data.
wr_sel  output  2**ADDR_W  registered one-hot decoded word-line select (all zero when wr_en=0).
grant_id  output  $clog2(NREQ)  registered index of last granted requester (debug).

Behaviour:
- Reset (reset=0 at edge): wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, grant_id=0, priority pointer ptr=0. ack is forced to 0 while reset=0.
- Arbitration (combinational, every cycle):
  - If busy=1 or req=0: ack=0, no grant.
  - Otherwise grant g = first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NREQ. ack = one-hot(g).
- Pointer: on an edge where a grant occurred, ptr <= (g+1) mod NREQ. Otherwise ptr is held.
- Write bundle, 1-cycle latency: on an edge with a grant, wr_addr <= req_addr[g], wr_data <= req_data[g], grant_id <= g.
  - If req_addr[g] != 31: wr_en <= 1 and wr_sel <= one-hot(req_addr[g]).
  - If req_addr[g] == 31: wr_en <= 0 and wr_sel <= 0. The ack is still issued.
- On an edge with no grant: wr_en <= 0, wr_sel <= 0, wr_addr/wr_data/grant_id hold.
- Handshake: a request is consumed on the edge where ack[i]=1. The requester must deassert or present its next request from the following cycle. req_addr/req_data must be stable while req=1 and not acked.
- Simultaneous requests: exactly one grant per cycle, no loss. Each requester waits at most NREQ-1 grants after being pending (fairness bound).
- Busy: busy=1 blocks grants and holds ptr. Pending requests stay pending. The write already on wr_* in that cycle is unaffected.
- Reset mid-operation: pending requests are not remembered. The pointer returns to 0. A write visible on wr_* is dropped (wr_en=0 next cycle).
- Invariants: popcount(ack) <= 1; wr_sel == (wr_en ? one-hot(wr_addr) : 0).

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=4'b1111 -> ack=0, wr_en=0, wr_sel=0. First cycle after release: ack=4'b0001.
- Single write: req[2]=1, addr=7, data=64'hDEAD_BEEF -> ack=4'b0100 same cycle. Next cycle wr_en=1, wr_addr=7, wr_sel=32'h0000_0080, wr_data=64'hDEAD_BEEF, grant_id=2.
- Round-robin: req=4'b1111 held, each acked requester re-requests immediately -> grant sequence 0,1,2,3,0,1 with one ack per cycle.
- Zero register: req[1]=1, addr=31, data=5 -> ack=4'b0010. Next cycle wr_en=0, wr_sel=0. ptr advances (next all-request grant is 2).
- Busy: req=4'b0011, busy=1 for 3 cycles -> ack=0, wr_en=0 throughout. On busy=0: grant 0, then 1 the following cycle.
- Wrap/fairness: after a grant to 3, req=4'b1001 -> grant 0 next, then 3. Reset mid-stream clears ptr so the next req=4'b1010 grants 1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writeback
// requesters; drives a registered write bundle with a one-hot word-line select.
module wb_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_data,
  input  logic                       busy,
  output logic [NREQ-1:0]            ack,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [(1<<ADDR_W)-1:0]     wr_sel,
  output logic [$clog2(NREQ)-1:0]    grant_id
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int SEL_W = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '1;

  // Handshake: requester i is consumed on the rising edge where ack[i]=1; until then
  // req[i], its address and its data must stay stable. ack is combinational.

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(off);
    if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
    return sum[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
  logic [PTR_W-1:0]  grant_id_q, grant_id_d;

  logic              found;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Scan ptr, ptr+1, ... modulo NREQ; the first pending requester wins.
  always_comb begin
    found     = 1'b0;
    cand      = '0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_valid = reset && !busy && found;
  assign sel_addr    = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data    = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  always_comb begin
    ack = '0;
    if (grant_valid) ack[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    if (grant_valid) begin
      ptr_d      = wrap_add(grant_idx, 1);
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      grant_id_d = grant_idx;
      // The zero register is acknowledged but never written.
      if (sel_addr != ZERO_REG) begin
        wr_en_d  = 1'b1;
        wr_sel_d = SEL_W'(1) << sel_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_sel_q   <= '0;
      grant_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_sel_q   <= wr_sel_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_sel   = wr_sel_q;
  assign grant_id = grant_id_q;

endmodule
